// File: rtl/rx_forward_filter.sv
// rx_forward_filter: per-port RX filter that makes drop, prune and mirror decisions, emits one metadata word per frame, and passes payload with MTU truncation.
// Define RX_FWD_STORM_CTRL_EN to build the broadcast/multicast token-bucket storm control.
module rx_forward_filter #(
  parameter int PORT_NUM       = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int METADATA_WIDTH = 64,
  parameter int CNT_WIDTH      = 16,
  parameter int TOKEN_WIDTH    = 16,
  parameter int REFILL_SHIFT   = 10
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_port_rxmac_down_regs,
  input  logic                      i_port_broadcast_drop_regs,
  input  logic                      i_port_multicast_drop_regs,
  input  logic                      i_port_loopback_drop_regs,
  input  logic [15:0]               i_port_mtu_regs,
  input  logic [PORT_NUM-1:0]       i_port_mirror_frwd_regs,
  input  logic [TOKEN_WIDTH-1:0]    i_storm_rate,
  input  logic [TOKEN_WIDTH-1:0]    i_storm_burst,
  input  logic                      i_frm_info_vld,
  input  logic [PORT_NUM-1:0]       i_rx_port,
  input  logic [2:0]                i_vlan_pri,
  input  logic                      i_frm_qbu,
  input  logic [1:0]                i_frm_cb_op,
  input  logic                      i_broadcast_frm_en,
  input  logic                      i_multicast_frm_en,
  input  logic                      i_lookback_frm_en,
  input  logic                      i_swlist_vld,
  input  logic [PORT_NUM-1:0]       i_swlist_tx_port,
  input  logic [DATA_WIDTH:0]       i_axi_data,
  input  logic [DATA_WIDTH/8-1:0]   i_axi_keep,
  input  logic                      i_axi_valid,
  output logic                      o_axi_ready,
  input  logic                      i_axi_last,
  output logic [DATA_WIDTH:0]       o_axi_data,
  output logic [DATA_WIDTH/8-1:0]   o_axi_keep,
  output logic                      o_axi_valid,
  input  logic                      i_axi_ready,
  output logic                      o_axi_last,
  output logic [METADATA_WIDTH-1:0] o_metadata,
  output logic                      o_metadata_valid,
  output logic                      o_metadata_last,
  input  logic                      i_metadata_ready,
  output logic                      o_ultrashort_pulse,
  output logic                      o_overlength_pulse,
  output logic                      o_crcerr_pulse,
  output logic [CNT_WIDTH-1:0]      o_loopback_cnt,
  output logic [CNT_WIDTH-1:0]      o_bcast_drop_cnt,
  output logic [CNT_WIDTH-1:0]      o_mcast_drop_cnt,
  output logic [CNT_WIDTH-1:0]      o_overlength_cnt
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int KCNT_W = $clog2(KEEP_W + 1);
  localparam int BCNT_W = 17;

  typedef enum logic [2:0] {S_IDLE, S_DECIDE, S_META, S_FWD, S_DISC} state_t;

  state_t              state;
  logic                info_got, sw_got;
  logic [PORT_NUM-1:0] lat_rx_port, lat_swlist;
  logic [2:0]          lat_vlan_pri;
  logic                lat_qbu;
  logic [1:0]          lat_cb_op;
  logic                lat_bcast, lat_mcast, lat_loop;
  logic [15:0]         mtu_q;
  logic [BCNT_W-1:0]   byte_cnt, cnt_next;
  logic [KCNT_W-1:0]   keep_bytes;
  logic                fwd, hs, over;

  logic [PORT_NUM-1:0] tx_dec;
  logic                is_bc, is_mc, bc_drop, mc_drop, drop;
  logic                bc_empty, mc_empty;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // NOTE: every variable written in always_comb gets a value first, so no latch is inferred.
  always_comb begin
    keep_bytes = '0;
    for (int i = 0; i < KEEP_W; i++) keep_bytes = keep_bytes + KCNT_W'(i_axi_keep[i]);
  end

  assign fwd      = (state == S_FWD);
  assign hs       = fwd & i_axi_valid & i_axi_ready;
  assign cnt_next = byte_cnt + BCNT_W'(keep_bytes);
  assign over     = fwd & (cnt_next > {1'b0, mtu_q});

  // Pass-through while forwarding; the truncating beat is forced to last with crcerr set.
  assign o_axi_valid = fwd & i_axi_valid;
  assign o_axi_ready = fwd ? i_axi_ready : (state == S_DISC);
  assign o_axi_keep  = fwd ? i_axi_keep : '0;
  assign o_axi_last  = fwd & (i_axi_last | over);
  assign o_axi_data  = fwd ? {i_axi_data[DATA_WIDTH] | over, i_axi_data[DATA_WIDTH-1:0]} : '0;

  // Broadcast wins over multicast: a frame flagged as both is treated purely as broadcast.
  always_comb begin
    tx_dec = lat_swlist | i_port_mirror_frwd_regs;
    if (lat_loop && i_port_loopback_drop_regs) tx_dec = tx_dec & ~lat_rx_port;
    is_bc   = lat_bcast;
    is_mc   = lat_mcast & ~lat_bcast;
    bc_drop = is_bc & (i_port_broadcast_drop_regs | bc_empty);
    mc_drop = is_mc & (i_port_multicast_drop_regs | mc_empty);
    drop    = i_port_rxmac_down_regs | bc_drop | mc_drop | (tx_dec == '0);
  end

`ifdef RX_FWD_STORM_CTRL_EN
  logic [REFILL_SHIFT-1:0] refill_timer;
  logic [TOKEN_WIDTH-1:0]  bc_tok, mc_tok;
  logic                    refill_tick, bc_consume, mc_consume;

  function automatic logic [TOKEN_WIDTH-1:0] tok_next(
    input logic [TOKEN_WIDTH-1:0] tok,
    input logic                   consume,
    input logic                   tick,
    input logic [TOKEN_WIDTH-1:0] rate,
    input logic [TOKEN_WIDTH-1:0] burst
  );
    logic [TOKEN_WIDTH:0] sum;
    sum = {1'b0, tok} - {{TOKEN_WIDTH{1'b0}}, consume} + (tick ? {1'b0, rate} : '0);
    return (sum > {1'b0, burst}) ? burst : sum[TOKEN_WIDTH-1:0];
  endfunction

  assign refill_tick = &refill_timer;
  assign bc_empty    = (bc_tok == '0);
  assign mc_empty    = (mc_tok == '0);
  assign bc_consume  = (state == S_DECIDE) & is_bc & ~drop;
  assign mc_consume  = (state == S_DECIDE) & is_mc & ~drop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      refill_timer <= '0;
      bc_tok       <= '0;
      mc_tok       <= '0;
    end else begin
      refill_timer <= refill_timer + REFILL_SHIFT'(1);
      bc_tok       <= tok_next(bc_tok, bc_consume, refill_tick, i_storm_rate, i_storm_burst);
      mc_tok       <= tok_next(mc_tok, mc_consume, refill_tick, i_storm_rate, i_storm_burst);
    end
  end
`else
  logic unused_storm;
  assign bc_empty     = 1'b0;
  assign mc_empty     = 1'b0;
  assign unused_storm = &{1'b0, i_storm_rate, i_storm_burst, 1'(REFILL_SHIFT)};
`endif

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= S_IDLE;
      info_got           <= 1'b0;
      sw_got             <= 1'b0;
      lat_rx_port        <= '0;
      lat_swlist         <= '0;
      lat_vlan_pri       <= '0;
      lat_qbu            <= 1'b0;
      lat_cb_op          <= '0;
      lat_bcast          <= 1'b0;
      lat_mcast          <= 1'b0;
      lat_loop           <= 1'b0;
      mtu_q              <= '0;
      byte_cnt           <= '0;
      o_metadata         <= '0;
      o_metadata_valid   <= 1'b0;
      o_metadata_last    <= 1'b0;
      o_ultrashort_pulse <= 1'b0;
      o_overlength_pulse <= 1'b0;
      o_crcerr_pulse     <= 1'b0;
      o_loopback_cnt     <= '0;
      o_bcast_drop_cnt   <= '0;
      o_mcast_drop_cnt   <= '0;
      o_overlength_cnt   <= '0;
    end else begin
      o_ultrashort_pulse <= 1'b0;
      o_overlength_pulse <= 1'b0;
      o_crcerr_pulse     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_frm_info_vld) begin
            info_got     <= 1'b1;
            lat_rx_port  <= i_rx_port;
            lat_vlan_pri <= i_vlan_pri;
            lat_qbu      <= i_frm_qbu;
            lat_cb_op    <= i_frm_cb_op;
            lat_bcast    <= i_broadcast_frm_en;
            lat_mcast    <= i_multicast_frm_en;
            lat_loop     <= i_lookback_frm_en;
          end
          if (i_swlist_vld) begin
            sw_got     <= 1'b1;
            lat_swlist <= i_swlist_tx_port;
          end
          if ((info_got | i_frm_info_vld) && (sw_got | i_swlist_vld)) begin
            info_got <= 1'b0;
            sw_got   <= 1'b0;
            state    <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          mtu_q    <= i_port_mtu_regs;
          byte_cnt <= '0;
          if (lat_loop) o_loopback_cnt <= sat_inc(o_loopback_cnt);
          if (bc_drop)  o_bcast_drop_cnt <= sat_inc(o_bcast_drop_cnt);
          if (mc_drop)  o_mcast_drop_cnt <= sat_inc(o_mcast_drop_cnt);
          if (drop) begin
            state <= S_DISC;
          end else begin
            o_metadata       <= METADATA_WIDTH'({lat_vlan_pri, lat_qbu, lat_cb_op, lat_rx_port, tx_dec});
            o_metadata_valid <= 1'b1;
            o_metadata_last  <= 1'b1;
            state            <= S_META;
          end
        end
        S_META: begin
          if (i_metadata_ready) begin
            o_metadata_valid <= 1'b0;
            o_metadata_last  <= 1'b0;
            state            <= S_FWD;
          end
        end
        S_FWD: begin
          if (hs) begin
            byte_cnt <= cnt_next;
            if (i_axi_last) begin
              o_ultrashort_pulse <= (cnt_next < BCNT_W'(64));
              o_crcerr_pulse     <= i_axi_data[DATA_WIDTH];
            end
            if (over) begin
              o_overlength_pulse <= 1'b1;
              o_overlength_cnt   <= sat_inc(o_overlength_cnt);
              state              <= i_axi_last ? S_IDLE : S_DISC;
            end else if (i_axi_last) begin
              state <= S_IDLE;
            end
          end
        end
        S_DISC: begin
          if (i_axi_valid && i_axi_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
